// File: rtl/rom_port_arbiter.sv
// Arbiter that shares the single combinational ROM read port between the
// instruction-fetch requester (F) and the literal-load requester (L).
// One request is granted per cycle. Its response comes back registered one
// cycle later on the winner's channel.
module rom_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int ROM_ADDR_MSB = 9,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  f_req_valid,
  output logic                  f_req_ready,
  input  logic [ADDR_WIDTH-1:0] f_req_addr,
  input  logic                  f_flush,
  output logic                  f_resp_valid,
  output logic [DATA_WIDTH-1:0] f_resp_data,
  output logic                  f_resp_err,
  input  logic                  l_req_valid,
  output logic                  l_req_ready,
  input  logic [ADDR_WIDTH-1:0] l_req_addr,
  output logic                  l_resp_valid,
  output logic [DATA_WIDTH-1:0] l_resp_data,
  output logic                  l_resp_err,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0] rom_data
);

  typedef enum logic [1:0] {
    TagNone,
    TagF,
    TagL
  } tag_e;

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  tag_e                  tag_q, tag_d;
  logic [3:0]            starve_q, starve_d;
  logic [DATA_WIDTH-1:0] fData_q, fData_d;
  logic [DATA_WIDTH-1:0] lData_q, lData_d;
  logic                  fErr_q, fErr_d;
  logic                  lErr_q, lErr_d;

  logic                  fGrant;
  logic                  lGrant;
  logic                  addrErr;

  // Grant selection: L normally wins a tie, but F wins once it has waited
  // STARVE_LIMIT L grants in a row. A flush blocks only F; L may still go.
  always_comb begin
    fGrant      = f_req_valid && !f_flush && (!l_req_valid || (starve_q == StarveMax));
    lGrant      = l_req_valid && !fGrant;
    f_req_ready = fGrant;
    l_req_ready = lGrant;
    rom_address = lGrant ? l_req_addr : f_req_addr;
    addrErr     = |rom_address[ADDR_WIDTH-1:ROM_ADDR_MSB+1];
  end

  // Next-state logic. It computes the response tag, the captured ROM words
  // and the F starvation counter.
  always_comb begin
    tag_d    = TagNone;
    starve_d = starve_q;
    fData_d  = fData_q;
    fErr_d   = fErr_q;
    lData_d  = lData_q;
    lErr_d   = lErr_q;

    if (fGrant) begin
      tag_d   = TagF;
      fData_d = addrErr ? '0 : rom_data;
      fErr_d  = addrErr;
    end else if (lGrant) begin
      tag_d   = TagL;
      lData_d = addrErr ? '0 : rom_data;
      lErr_d  = addrErr;
    end

    if (fGrant || !f_req_valid) begin
      starve_d = '0;
    end else if (lGrant && (starve_q != StarveMax)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // State registers. An asynchronous reset drops any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q    <= TagNone;
      starve_q <= '0;
      fData_q  <= '0;
      fErr_q   <= 1'b0;
      lData_q  <= '0;
      lErr_q   <= 1'b0;
    end else begin
      tag_q    <= tag_d;
      starve_q <= starve_d;
      fData_q  <= fData_d;
      fErr_q   <= fErr_d;
      lData_q  <= lData_d;
      lErr_q   <= lErr_d;
    end
  end

  // Response outputs. A flush in the response cycle kills the pending F pulse.
  always_comb begin
    f_resp_valid = (tag_q == TagF) && !f_flush;
    l_resp_valid = (tag_q == TagL);
    f_resp_data  = fData_q;
    f_resp_err   = fErr_q;
    l_resp_data  = lData_q;
    l_resp_err   = lErr_q;
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed self-checking bench for rom_port_arbiter.
// Each step pushes the response it expects for the next cycle onto a queue.
// That entry is popped and compared one cycle later.
module tb_rom_port_arbiter;

  localparam int GN = 0;
  localparam int GF = 1;
  localparam int GL = 2;

  typedef struct {
    logic        fv;
    logic        lv;
    logic [31:0] data;
    logic        err;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_req_valid = 1'b0;
  logic        f_req_ready;
  logic [31:0] f_req_addr = '0;
  logic        f_flush = 1'b0;
  logic        f_resp_valid;
  logic [31:0] f_resp_data;
  logic        f_resp_err;
  logic        l_req_valid = 1'b0;
  logic        l_req_ready;
  logic [31:0] l_req_addr = '0;
  logic        l_resp_valid;
  logic [31:0] l_resp_data;
  logic        l_resp_err;
  logic [31:0] rom_address;
  logic [31:0] rom_data;

  int compareCount = 0;
  int failCount = 0;
  resp_t expQ[$];

  always #5 clk = ~clk;

  // The ROM contents are an arbitrary address-dependent pattern.
  function automatic logic [31:0] romWord(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0] + 16'h1234};
  endfunction

  assign rom_data = romWord(rom_address);

  rom_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_addr(f_req_addr),
    .f_flush(f_flush), .f_resp_valid(f_resp_valid), .f_resp_data(f_resp_data),
    .f_resp_err(f_resp_err),
    .l_req_valid(l_req_valid), .l_req_ready(l_req_ready), .l_req_addr(l_req_addr),
    .l_resp_valid(l_resp_valid), .l_resp_data(l_resp_data), .l_resp_err(l_resp_err),
    .rom_address(rom_address), .rom_data(rom_data)
  );

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pops the response expected in this cycle and compares it.
  // A flush in this cycle suppresses any F pulse.
  task automatic checkOutput();
    resp_t e;
    logic  efv;
    e = '{fv: 1'b0, lv: 1'b0, data: 32'h0, err: 1'b0};
    if (expQ.size() > 0) e = expQ.pop_front();
    efv = e.fv && !f_flush;
    compare("f_resp_valid", {31'b0, f_resp_valid}, {31'b0, efv});
    compare("l_resp_valid", {31'b0, l_resp_valid}, {31'b0, e.lv});
    if (efv) begin
      compare("f_resp_data", f_resp_data, e.data);
      compare("f_resp_err", {31'b0, f_resp_err}, {31'b0, e.err});
    end
    if (e.lv) begin
      compare("l_resp_data", l_resp_data, e.data);
      compare("l_resp_err", {31'b0, l_resp_err}, {31'b0, e.err});
    end
  endtask

  // Drives one cycle of requests and checks the response due this cycle.
  // It also checks the expected grant and queues the resulting response.
  task automatic applyStimulus(input logic fv, input logic [31:0] fa,
                               input logic lv, input logic [31:0] la,
                               input logic fl, input int g);
    resp_t       e;
    logic [31:0] a;
    f_req_valid = fv;
    f_req_addr  = fa;
    l_req_valid = lv;
    l_req_addr  = la;
    f_flush     = fl;
    #2;
    checkOutput();
    compare("f_req_ready", {31'b0, f_req_ready}, {31'b0, (g == GF)});
    compare("l_req_ready", {31'b0, l_req_ready}, {31'b0, (g == GL)});
    a = (g == GL) ? la : fa;
    compare("rom_address", rom_address, a);
    e.fv   = (g == GF);
    e.lv   = (g == GL);
    e.err  = |a[31:10];
    e.data = e.err ? 32'h0 : romWord(a);
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Hold reset with both requesters active.
    // Responses stay zero, and ready still follows the grant rules.
    f_req_valid = 1'b1;
    f_req_addr  = 32'h20;
    l_req_valid = 1'b1;
    l_req_addr  = 32'h24;
    repeat (2) @(posedge clk);
    #1;
    compare("rst f_resp_valid", {31'b0, f_resp_valid}, 32'h0);
    compare("rst l_resp_valid", {31'b0, l_resp_valid}, 32'h0);
    compare("rst f_resp_data", f_resp_data, 32'h0);
    compare("rst l_resp_data", l_resp_data, 32'h0);
    compare("rst f_resp_err", {31'b0, f_resp_err}, 32'h0);
    compare("rst l_resp_err", {31'b0, l_resp_err}, 32'h0);
    compare("rst l_req_ready", {31'b0, l_req_ready}, 32'h1);
    compare("rst rom_address", rom_address, 32'h24);
    rst_n = 1'b1;

    // F alone issues back-to-back requests.
    applyStimulus(1, 32'h0, 0, 32'h0, 0, GF);
    applyStimulus(1, 32'h2, 0, 32'h0, 0, GF);
    applyStimulus(1, 32'h4, 0, 32'h0, 0, GF);
    applyStimulus(0, 32'h0, 0, 32'h0, 0, GN);

    // Both requesters are valid continuously.
    // F must win every fourth grant.
    applyStimulus(1, 32'h100, 1, 32'h200, 0, GL);
    applyStimulus(1, 32'h104, 1, 32'h204, 0, GL);
    applyStimulus(1, 32'h108, 1, 32'h208, 0, GL);
    applyStimulus(1, 32'h10C, 1, 32'h20C, 0, GF);
    applyStimulus(1, 32'h110, 1, 32'h210, 0, GL);
    applyStimulus(1, 32'h114, 1, 32'h214, 0, GL);
    applyStimulus(1, 32'h118, 1, 32'h218, 0, GL);
    applyStimulus(1, 32'h11C, 1, 32'h21C, 0, GF);
    applyStimulus(0, 32'h0, 0, 32'h0, 0, GN);

    // Out-of-range addresses still consume one grant and one response slot.
    applyStimulus(0, 32'h0, 1, 32'h0000_0400, 0, GL);
    applyStimulus(1, 32'h10, 0, 32'h0, 0, GF);
    applyStimulus(1, 32'h8000_0000, 0, 32'h0, 0, GF);
    applyStimulus(1, 32'h3FC, 0, 32'h0, 0, GF);
    applyStimulus(0, 32'h0, 0, 32'h0, 0, GN);

    // A flush in the response cycle kills the F pulse and blocks F that cycle.
    applyStimulus(1, 32'h8, 0, 32'h0, 0, GF);
    applyStimulus(1, 32'hC, 0, 32'h0, 1, GN);
    applyStimulus(0, 32'h0, 0, 32'h0, 0, GN);
    applyStimulus(1, 32'h30, 1, 32'h34, 1, GL);
    applyStimulus(1, 32'h38, 0, 32'h0, 0, GF);
    applyStimulus(0, 32'h0, 0, 32'h0, 0, GN);

    // Reset arrives while an L response is pending.
    applyStimulus(0, 32'h0, 1, 32'h40, 0, GL);
    f_req_valid = 1'b0;
    l_req_valid = 1'b0;
    #1;
    checkOutput();
    rst_n = 1'b0;
    #1;
    compare("midrst l_resp_valid", {31'b0, l_resp_valid}, 32'h0);
    compare("midrst l_resp_data", l_resp_data, 32'h0);
    compare("midrst l_resp_err", {31'b0, l_resp_err}, 32'h0);
    expQ.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(0, 32'h0, 0, 32'h0, 0, GN);
    applyStimulus(0, 32'h0, 0, 32'h0, 0, GN);
    applyStimulus(0, 32'h0, 0, 32'h0, 0, GN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

  // A watchdog ends the run if the directed sequence ever stalls.
  initial begin
    #100000;
    failCount++;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $fatal(1, "[TB] timeout");
  end

endmodule
